// File: rtl/comm_pkg.sv
// Shared types and constants for the logic-analyzer host command master.
package comm_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } cm_state_t;

  localparam int FRAME_BITS       = 10;
  localparam int DEFAULT_BAUD_DIV = 868;
endpackage

// File: rtl/uart_trx.sv
// 8N1 UART transmitter and receiver sharing one baud divisor.
module uart_trx
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx,
  output logic       o_tx_done,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_rdy,
  output logic       o_rx_ferr
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  logic          r_tx;
  logic          r_tx_busy;
  logic [CW-1:0] r_tx_baud;
  logic [3:0]    r_tx_bit;
  logic [8:0]    r_tx_sr;
  logic          w_tx_end;

  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  logic          r_rx_busy;
  logic [CW-1:0] r_rx_baud;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic [7:0]    r_rx_byte;
  logic          r_rx_rdy;
  logic          r_rx_ferr;

  // The last clock of a stop bit doubles as the slot for loading the next frame.
  assign w_tx_end  = r_tx_busy && (r_tx_bit == LAST_BIT) && (r_tx_baud == BIT_END);
  assign o_tx      = r_tx;
  assign o_tx_done = w_tx_end;
  assign o_rx_byte = r_rx_byte;
  assign o_rx_rdy  = r_rx_rdy;
  assign o_rx_ferr = r_rx_ferr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx      <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_baud <= '0;
      r_tx_bit  <= 4'd0;
      r_tx_sr   <= '1;
    end else if (i_tx_start && (!r_tx_busy || w_tx_end)) begin
      r_tx      <= 1'b0;
      r_tx_busy <= 1'b1;
      r_tx_baud <= '0;
      r_tx_bit  <= 4'd0;
      r_tx_sr   <= {1'b1, i_tx_data};
    end else if (r_tx_busy) begin
      if (r_tx_baud == BIT_END) begin
        r_tx_baud <= '0;
        if (r_tx_bit == LAST_BIT) begin
          r_tx_busy <= 1'b0;
          r_tx      <= 1'b1;
        end else begin
          r_tx     <= r_tx_sr[0];
          r_tx_sr  <= {1'b1, r_tx_sr[8:1]};
          r_tx_bit <= r_tx_bit + 4'd1;
        end
      end else begin
        r_tx_baud <= r_tx_baud + CW'(1);
      end
    end
  end

  // r_rx_s3 only feeds falling-edge detection, so a low line after a bad stop bit does not re-arm.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_busy <= 1'b0;
      r_rx_baud <= '0;
      r_rx_bit  <= 4'd0;
      r_rx_sh   <= 8'h00;
      r_rx_byte <= 8'h00;
      r_rx_rdy  <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      r_rx_rdy  <= 1'b0;
      r_rx_ferr <= 1'b0;
      if (!r_rx_busy) begin
        if (!r_rx_s2 && r_rx_s3) begin
          r_rx_busy <= 1'b1;
          r_rx_baud <= '0;
          r_rx_bit  <= 4'd0;
        end
      end else if (r_rx_baud == ((r_rx_bit == 4'd0) ? HALF_END : BIT_END)) begin
        r_rx_baud <= '0;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_s2) begin
            r_rx_busy <= 1'b0;
          end else begin
            r_rx_bit <= 4'd1;
          end
        end else if (r_rx_bit == LAST_BIT) begin
          r_rx_busy <= 1'b0;
          if (r_rx_s2) begin
            r_rx_rdy  <= 1'b1;
            r_rx_byte <= r_rx_sh;
          end else begin
            r_rx_ferr <= 1'b1;
          end
        end else begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 4'd1;
        end
      end else begin
        r_rx_baud <= r_rx_baud + CW'(1);
      end
    end
  end
endmodule

// File: rtl/comm_master_n.sv
// Host-side command master: sends a multi-byte command over UART and gathers
// a programmable-length response with an inter-byte timeout.
module comm_master_n
  import comm_pkg::*;
#(
  parameter int CMD_BYTES      = 2,
  parameter int RESP_BYTES_MAX = 4,
  parameter int BAUD_DIV       = DEFAULT_BAUD_DIV,
  parameter int TIMEOUT_CYC    = 65536
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [8*CMD_BYTES-1:0]               cmd,
  input  logic                                 send_cmd,
  input  logic [$clog2(RESP_BYTES_MAX+1)-1:0]  resp_len,
  input  logic                                 clr_resp_rdy,
  input  logic                                 RX,
  output logic                                 TX,
  output logic                                 busy,
  output logic                                 cmd_sent,
  output logic [8*RESP_BYTES_MAX-1:0]          resp,
  output logic [$clog2(RESP_BYTES_MAX+1)-1:0]  resp_cnt,
  output logic                                 resp_rdy,
  output logic                                 timeout
);
  localparam int LW     = $clog2(RESP_BYTES_MAX + 1);
  localparam int CBW    = $clog2(CMD_BYTES + 1);
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);
  localparam int CMD_W  = 8 * CMD_BYTES;
  localparam int RESP_W = 8 * RESP_BYTES_MAX;

  cm_state_t         r_state;
  logic [CMD_W-1:0]  r_cmd_sr;
  logic [CBW-1:0]    r_left;
  logic              r_first;
  logic [LW-1:0]     r_len;
  logic [RESP_W-1:0] r_resp;
  logic [LW-1:0]     r_resp_cnt;
  logic [TW-1:0]     r_to_cnt;
  logic              r_busy, r_cmd_sent, r_resp_rdy, r_timeout;

  logic              w_tx_start, w_tx_done, w_rx_rdy, w_rx_ferr, w_rx_good;
  logic [7:0]        w_rx_byte;
  logic [LW-1:0]     w_cnt_inc;

  // Next byte is handed over in the stop bit's last clock so frames run back to back.
  assign w_tx_start = (r_state == SEND) && (r_first || (w_tx_done && (r_left != '0)));
  assign w_rx_good  = w_rx_rdy && !w_rx_ferr;
  assign w_cnt_inc  = r_resp_cnt + LW'(1);

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tx_start (w_tx_start),
    .i_tx_data  (r_cmd_sr[CMD_W-1 -: 8]),
    .o_tx       (TX),
    .o_tx_done  (w_tx_done),
    .i_rx       (RX),
    .o_rx_byte  (w_rx_byte),
    .o_rx_rdy   (w_rx_rdy),
    .o_rx_ferr  (w_rx_ferr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cmd_sr   <= '0;
      r_left     <= '0;
      r_first    <= 1'b0;
      r_len      <= '0;
      r_resp     <= '0;
      r_resp_cnt <= '0;
      r_to_cnt   <= '0;
      r_busy     <= 1'b0;
      r_cmd_sent <= 1'b0;
      r_resp_rdy <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (clr_resp_rdy) begin
        r_resp_rdy <= 1'b0;
        r_timeout  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (send_cmd) begin
            r_state    <= LOAD;
            r_cmd_sr   <= cmd;
            r_left     <= CBW'(CMD_BYTES);
            r_len      <= resp_len;
            r_resp     <= '0;
            r_resp_cnt <= '0;
            r_resp_rdy <= 1'b0;
            r_timeout  <= 1'b0;
            r_cmd_sent <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        LOAD: begin
          r_first <= 1'b1;
          r_state <= SEND;
        end
        SEND: begin
          if (w_tx_start) begin
            r_cmd_sr <= r_cmd_sr << 8;
            r_left   <= r_left - CBW'(1);
            r_first  <= 1'b0;
          end
          if (w_tx_done && (r_left == '0)) begin
            r_cmd_sent <= 1'b1;
            r_to_cnt   <= '0;
            r_state    <= (r_len == '0) ? DONE : RESP;
          end
        end
        RESP: begin
          if (w_rx_good) begin
            r_resp     <= (r_resp << 8) | RESP_W'(w_rx_byte);
            r_resp_cnt <= w_cnt_inc;
            r_to_cnt   <= '0;
            if (w_cnt_inc == r_len) begin
              r_state <= DONE;
            end
          end else if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        DONE: begin
          r_resp_rdy <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign cmd_sent = r_cmd_sent;
  assign resp     = r_resp;
  assign resp_cnt = r_resp_cnt;
  assign resp_rdy = r_resp_rdy;
  assign timeout  = r_timeout;
endmodule
